// File: rtl/dp_ram_pkg.sv
// Shared constants, FSM state type and lane-count helper for the dual-port RAM.
package dp_ram_pkg;

    // Read-during-write policy selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Controller states: sweep-to-zero after reset, then normal service
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Number of byte lanes covered by the write-enable vector
    function automatic int lane_count(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/dp_ram_out_pipe.sv
// Optional per-port output register: delays {valid, data} by one cycle.
// Data only reloads when a valid word arrives, so the output holds otherwise.
import dp_ram_pkg::*;

module dp_ram_out_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stage_vld,
    input  logic [W-1:0] stage_data,
    output logic         vld,
    output logic [W-1:0] data
);

    logic         vld_reg;
    logic [W-1:0] data_reg;

    // Register the valid strobe every cycle; capture data only with a valid word
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg  <= 1'b0;
            data_reg <= '0;
        end else begin
            vld_reg <= stage_vld;
            if (stage_vld) begin
                data_reg <= stage_data;
            end
        end
    end

    assign vld  = vld_reg;
    assign data = data_reg;

endmodule

// File: rtl/dp_ram_be_clr.sv
// True dual-port RAM with byte-lane write enables, selectable read-during-write
// behaviour, port-A-wins collision arbitration and a zeroing sweep after reset.
import dp_ram_pkg::*;

module dp_ram_be_clr #(
    parameter int DATA_W   = 8,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_a,
    input  logic [lane_count(DATA_W, BYTE_W)-1:0] we_a,
    input  logic [ADDR_W-1:0]                addr_a,
    input  logic [DATA_W-1:0]                din_a,
    output logic [DATA_W-1:0]                dout_a,
    output logic                             vld_a,
    input  logic                             en_b,
    input  logic [lane_count(DATA_W, BYTE_W)-1:0] we_b,
    input  logic [ADDR_W-1:0]                addr_b,
    input  logic [DATA_W-1:0]                din_b,
    output logic [DATA_W-1:0]                dout_b,
    output logic                             vld_b,
    output logic                             busy,
    output logic                             collision
);

    localparam int NB = lane_count(DATA_W, BYTE_W);
    localparam int CW = ADDR_W + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            sweep;
    logic            clear_en;

    logic            issue_a, issue_b;
    logic            in_a, in_b;
    logic            wr_a, wr_b;
    logic            same_addr;
    logic            collision_next;
    logic [IW-1:0]   idx_a, idx_b;

    logic [DATA_W-1:0] fmask_a, fdata_a, fmask_b, fdata_b;

    logic [DATA_W-1:0] raw_a_reg, raw_b_reg;
    logic [DATA_W-1:0] fmask_a_reg, fdata_a_reg, fmask_b_reg, fdata_b_reg;
    logic              oor_a_reg, oor_b_reg;
    logic              vld1_a_reg, vld1_b_reg;
    logic              collision_reg;
    logic [DATA_W-1:0] d1_a, d1_b;

    // Controller state and sweep counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sweep through every word once, then hand over to normal service
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sweep      = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                sweep    = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_C) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg != ST_RUN);
    assign clear_en = sweep & ~rst;

    // Access qualification and address range checks
    assign issue_a   = en_a & ~busy & ~rst;
    assign issue_b   = en_b & ~busy & ~rst;
    assign in_a      = ({1'b0, addr_a} < DEPTH_C);
    assign in_b      = ({1'b0, addr_b} < DEPTH_C);
    assign wr_a      = issue_a & in_a;
    assign wr_b      = issue_b & in_b;
    assign idx_a     = addr_a[IW-1:0];
    assign idx_b     = addr_b[IW-1:0];
    assign same_addr = (addr_a == addr_b);
    assign collision_next = issue_a & issue_b & same_addr & (|(we_a & we_b));

    // Per-lane forwarding of this cycle's writes into each port's read word;
    // a lane written by A takes A's data, so A wins any overlap.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic hit_aa, hit_ba, hit_ab, hit_bb;
            assign hit_aa = wr_a & we_a[gi];
            assign hit_ba = wr_b & we_b[gi] & same_addr;
            assign hit_ab = wr_a & we_a[gi] & same_addr;
            assign hit_bb = wr_b & we_b[gi];

            assign fmask_a[gi*BYTE_W +: BYTE_W] = {BYTE_W{WRITE_FIRST & (hit_aa | hit_ba)}};
            assign fdata_a[gi*BYTE_W +: BYTE_W] = hit_aa ? din_a[gi*BYTE_W +: BYTE_W]
                                                         : din_b[gi*BYTE_W +: BYTE_W];
            assign fmask_b[gi*BYTE_W +: BYTE_W] = {BYTE_W{WRITE_FIRST & (hit_ab | hit_bb)}};
            assign fdata_b[gi*BYTE_W +: BYTE_W] = hit_ab ? din_a[gi*BYTE_W +: BYTE_W]
                                                         : din_b[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Array writes: sweep zeroing, else byte-lane writes with B first so A overrides
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[cnt_reg[IW-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && we_b[i]) begin
                    mem[idx_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
                end
                if (wr_a && we_a[i]) begin
                    mem[idx_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered reads (pre-edge word) plus captured forwarding info per port
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_a_reg     <= '0;
            raw_b_reg     <= '0;
            fmask_a_reg   <= '0;
            fdata_a_reg   <= '0;
            fmask_b_reg   <= '0;
            fdata_b_reg   <= '0;
            oor_a_reg     <= 1'b0;
            oor_b_reg     <= 1'b0;
            vld1_a_reg    <= 1'b0;
            vld1_b_reg    <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            vld1_a_reg    <= issue_a;
            vld1_b_reg    <= issue_b;
            collision_reg <= collision_next;
            if (issue_a) begin
                raw_a_reg   <= mem[idx_a];
                oor_a_reg   <= ~in_a;
                fmask_a_reg <= fmask_a;
                fdata_a_reg <= fdata_a;
            end
            if (issue_b) begin
                raw_b_reg   <= mem[idx_b];
                oor_b_reg   <= ~in_b;
                fmask_b_reg <= fmask_b;
                fdata_b_reg <= fdata_b;
            end
        end
    end

    // First-stage read word: out-of-range reads return zero
    assign d1_a = oor_a_reg ? '0 : ((raw_a_reg & ~fmask_a_reg) | (fdata_a_reg & fmask_a_reg));
    assign d1_b = oor_b_reg ? '0 : ((raw_b_reg & ~fmask_b_reg) | (fdata_b_reg & fmask_b_reg));

    assign collision = collision_reg;

    generate
        if (OUT_REG != 0) begin : g_pipe
            dp_ram_out_pipe #(.W(DATA_W)) u_pipe_a (
                .clk        (clk),
                .rst        (rst),
                .stage_vld  (vld1_a_reg),
                .stage_data (d1_a),
                .vld        (vld_a),
                .data       (dout_a)
            );
            dp_ram_out_pipe #(.W(DATA_W)) u_pipe_b (
                .clk        (clk),
                .rst        (rst),
                .stage_vld  (vld1_b_reg),
                .stage_data (d1_b),
                .vld        (vld_b),
                .data       (dout_b)
            );
        end else begin : g_direct
            assign vld_a  = vld1_a_reg;
            assign dout_a = d1_a;
            assign vld_b  = vld1_b_reg;
            assign dout_b = d1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// Directed bench: a read-first/registered-output instance and a write-first/
// latency-1 instance with a wider address space share the same stimulus.
module tb_dp_ram_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [31:0] dout_a, dout_b, dout_a_wf, dout_b_wf;
    logic        vld_a, vld_b, vld_a_wf, vld_b_wf;
    logic        busy, collision, busy_wf, collision_wf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dp_ram_be_clr #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .DEPTH(16),
                    .RDW_MODE(0), .OUT_REG(1)) dut (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a[3:0]), .din_a(din_a),
        .dout_a(dout_a), .vld_a(vld_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b[3:0]), .din_b(din_b),
        .dout_b(dout_b), .vld_b(vld_b),
        .busy(busy), .collision(collision)
    );

    dp_ram_be_clr #(.DATA_W(32), .BYTE_W(8), .ADDR_W(5), .DEPTH(16),
                    .RDW_MODE(1), .OUT_REG(0)) dut_wf (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a_wf), .vld_a(vld_a_wf),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b_wf), .vld_b(vld_b_wf),
        .busy(busy_wf), .collision(collision_wf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [3:0] we, input logic [31:0] d);
        en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
        cyc();
        idle();
        $display("write A addr %0d we %b data %h", a, we, d);
    endtask

    // Read on port A; wf result appears after the issue edge, main one edge later
    task automatic rd_a(input logic [4:0] a, output logic [31:0] d, output logic v,
                        output logic [31:0] dwf, output logic vwf);
        en_a = 1'b1; we_a = 4'h0; addr_a = a;
        cyc();
        dwf = dout_a_wf; vwf = vld_a_wf;
        idle();
        cyc();
        d = dout_a; v = vld_a;
        $display("read A addr %0d -> %h (vld %0b) / wf %h (vld %0b)", a, d, v, dwf, vwf);
    endtask

    // Count edges from reset release until busy falls, checking no valid leaks out
    task automatic count_clear(input string tag, input logic gate_write);
        int k;
        logic seen;
        k = 0; seen = 1'b0;
        if (gate_write) begin
            en_a = 1'b1; we_a = 4'hF; addr_a = 5'd0; din_a = 32'hFFFF_FFFF;
        end
        rst = 1'b0;
        do begin
            cyc();
            k++;
            if (vld_a || vld_a_wf) seen = 1'b1;
        end while (busy && k < 40);
        idle();
        n_cmp++;
        if (k !== 16) begin
            n_bad++; $display("FAIL %s_busy_len: got %0d cycles, want 16", tag, k);
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL %s_vld_while_busy: got %0b want 0", tag, seen);
        end
        n_cmp++;
        if (busy_wf !== 1'b0) begin
            n_bad++; $display("FAIL %s_busy_wf: got %0b want 0", tag, busy_wf);
        end
        $display("%s: busy for %0d cycles", tag, k);
    endtask

    task automatic test_reset();
        idle(); addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        rst = 1'b1;
        cyc(); cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %0b want 1", busy); end
        n_cmp++;
        if (vld_a !== 1'b0 || vld_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_vld: got %0b%0b want 00", vld_a, vld_b);
        end
        n_cmp++;
        if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
            n_bad++; $display("FAIL reset_dout: got %h %h want 0", dout_a, dout_b);
        end
        n_cmp++;
        if (collision !== 1'b0) begin n_bad++; $display("FAIL reset_collision: got %0b want 0", collision); end
        n_cmp++;
        if (dout_a_wf !== 32'h0 || vld_a_wf !== 1'b0) begin
            n_bad++; $display("FAIL reset_wf: got %h/%0b want 0/0", dout_a_wf, vld_a_wf);
        end
        count_clear("clear", 1'b1);
    endtask

    // Back-to-back reads of every address after the sweep
    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                en_a = 1'b1; we_a = 4'h0; addr_a = 5'(i);
            end else begin
                idle();
            end
            cyc();
            if (i >= 1 && i <= 16) begin
                n_cmp++;
                if (vld_a !== 1'b1 || dout_a !== 32'h0) begin
                    n_bad++; $display("FAIL sweep_read_%0d: got %h/%0b want 00000000/1", i - 1, dout_a, vld_a);
                end
            end else begin
                n_cmp++;
                if (vld_a !== 1'b0) begin n_bad++; $display("FAIL sweep_vld_idle_%0d: got %0b want 0", i, vld_a); end
            end
            if (i < 16) begin
                n_cmp++;
                if (vld_a_wf !== 1'b1 || dout_a_wf !== 32'h0) begin
                    n_bad++; $display("FAIL sweep_wf_%0d: got %h/%0b want 00000000/1", i, dout_a_wf, vld_a_wf);
                end
            end
            $display("sweep step %0d: dout_a %h vld_a %0b", i, dout_a, vld_a);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d, dwf;
        logic v, vwf;
        wr_a(5'd3, 4'b1111, 32'hAABB_CCDD);
        wr_a(5'd3, 4'b0101, 32'h1122_3344);
        rd_a(5'd3, d, v, dwf, vwf);
        n_cmp++;
        if (d !== 32'hAA22_CC44 || v !== 1'b1) begin
            n_bad++; $display("FAIL byte_en: got %h/%0b want aa22cc44/1", d, v);
        end
        n_cmp++;
        if (dwf !== 32'hAA22_CC44 || vwf !== 1'b1) begin
            n_bad++; $display("FAIL byte_en_wf: got %h/%0b want aa22cc44/1", dwf, vwf);
        end
        cyc();
        n_cmp++;
        if (dout_a !== 32'hAA22_CC44 || vld_a !== 1'b0) begin
            n_bad++; $display("FAIL dout_hold: got %h/%0b want aa22cc44/0", dout_a, vld_a);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d, dwf;
        logic v, vwf;
        en_a = 1'b1; we_a = 4'b0011; addr_a = 5'd5; din_a = 32'h1111_1111;
        en_b = 1'b1; we_b = 4'b0110; addr_b = 5'd5; din_b = 32'h2222_2222;
        cyc();
        idle();
        $display("collision write A/B addr 5");
        n_cmp++;
        if (collision !== 1'b1 || collision_wf !== 1'b1) begin
            n_bad++; $display("FAIL collision_pulse: got %0b/%0b want 1/1", collision, collision_wf);
        end
        n_cmp++;
        if (dout_a_wf !== 32'h0022_1111 || dout_b_wf !== 32'h0022_1111) begin
            n_bad++; $display("FAIL collision_wf_merge: got %h %h want 00221111", dout_a_wf, dout_b_wf);
        end
        cyc();
        n_cmp++;
        if (collision !== 1'b0) begin n_bad++; $display("FAIL collision_one_cycle: got %0b want 0", collision); end
        rd_a(5'd5, d, v, dwf, vwf);
        n_cmp++;
        if (d !== 32'h0022_1111 || dwf !== 32'h0022_1111) begin
            n_bad++; $display("FAIL collision_data: got %h/%h want 00221111", d, dwf);
        end
        // Same address, disjoint lanes: both land, no collision flag
        en_a = 1'b1; we_a = 4'b0001; addr_a = 5'd6; din_a = 32'h0000_00AB;
        en_b = 1'b1; we_b = 4'b0010; addr_b = 5'd6; din_b = 32'h0000_CD00;
        cyc();
        idle();
        $display("disjoint write A/B addr 6");
        n_cmp++;
        if (collision !== 1'b0) begin n_bad++; $display("FAIL no_overlap_collision: got %0b want 0", collision); end
        rd_a(5'd6, d, v, dwf, vwf);
        n_cmp++;
        if (d !== 32'h0000_CDAB || dwf !== 32'h0000_CDAB) begin
            n_bad++; $display("FAIL disjoint_data: got %h/%h want 0000cdab", d, dwf);
        end
    endtask

    task automatic test_rdw();
        logic [31:0] d, dwf;
        logic v, vwf;
        wr_a(5'd2, 4'b1111, 32'h0000_005A);
        en_a = 1'b1; we_a = 4'b1111; addr_a = 5'd2; din_a = 32'h0000_00A5;
        en_b = 1'b1; we_b = 4'b0000; addr_b = 5'd2;
        cyc();
        idle();
        $display("rdw: A writes a5, B reads addr 2");
        n_cmp++;
        if (dout_b_wf !== 32'h0000_00A5 || vld_b_wf !== 1'b1) begin
            n_bad++; $display("FAIL rdw_write_first_b: got %h/%0b want 000000a5/1", dout_b_wf, vld_b_wf);
        end
        n_cmp++;
        if (dout_a_wf !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL rdw_write_first_a: got %h want 000000a5", dout_a_wf);
        end
        cyc();
        n_cmp++;
        if (dout_b !== 32'h0000_005A || vld_b !== 1'b1) begin
            n_bad++; $display("FAIL rdw_read_first_b: got %h/%0b want 0000005a/1", dout_b, vld_b);
        end
        n_cmp++;
        if (dout_a !== 32'h0000_005A) begin
            n_bad++; $display("FAIL rdw_read_first_a: got %h want 0000005a", dout_a);
        end
        rd_a(5'd2, d, v, dwf, vwf);
        n_cmp++;
        if (d !== 32'h0000_00A5 || dwf !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL rdw_after: got %h/%h want 000000a5", d, dwf);
        end
    endtask

    // Address 19 is beyond DEPTH for the wide instance but aliases to 3 on the narrow one
    task automatic test_out_of_range();
        logic [31:0] d, dwf;
        logic v, vwf;
        wr_a(5'd19, 4'b1111, 32'hDEAD_BEEF);
        rd_a(5'd19, d, v, dwf, vwf);
        n_cmp++;
        if (dwf !== 32'h0 || vwf !== 1'b1) begin
            n_bad++; $display("FAIL oor_read: got %h/%0b want 00000000/1", dwf, vwf);
        end
        n_cmp++;
        if (d !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL alias_read: got %h want deadbeef", d);
        end
        rd_a(5'd3, d, v, dwf, vwf);
        n_cmp++;
        if (dwf !== 32'hAA22_CC44) begin
            n_bad++; $display("FAIL oor_write_discarded: got %h want aa22cc44", dwf);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d, dwf;
        logic v, vwf;
        rst = 1'b1;
        cyc();
        n_cmp++;
        if (dout_a !== 32'h0 || dout_a_wf !== 32'h0 || dout_b !== 32'h0) begin
            n_bad++; $display("FAIL rst_clears_dout: got %h %h %h want 0", dout_a, dout_a_wf, dout_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        cyc();
        n_cmp++;
        if (busy !== 1'b1 || vld_a !== 1'b0 || vld_b !== 1'b0) begin
            n_bad++; $display("FAIL mid_clear_rst: got busy %0b vld %0b%0b want 1 00", busy, vld_a, vld_b);
        end
        count_clear("mid_clear", 1'b0);
        rd_a(5'd3, d, v, dwf, vwf);
        n_cmp++;
        if (d !== 32'h0 || dwf !== 32'h0 || v !== 1'b1) begin
            n_bad++; $display("FAIL cleared_after_reset: got %h/%h/%0b want 0/0/1", d, dwf, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_enables();
        test_collision();
        test_rdw();
        test_out_of_range();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dp_ram_be_clr.md
Name: dp_ram_be_clr

Overview:
Parametrised true dual-port synchronous RAM with per-byte write enables and a selectable read-during-write policy. It adds an optional output pipeline stage with per-port valid flags, deterministic cross-port collision arbitration, and a hardware clear sequence after reset. It serves as the shared scratch/buffer memory for lab datapaths that need two independent masters on one clock.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of BYTE_W
BYTE_W, 8, lane width covered by one write-enable bit
ADDR_W, 4, address width
DEPTH, 16, number of words; must be ≤ 2**ADDR_W
RDW_MODE, 0, read-during-write policy: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 1, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en_a  in  1  port A access request
we_a  in  DATA_W/BYTE_W  port A per-lane write enables; all-zero means read-only
addr_a  in  ADDR_W  port A address
din_a  in  DATA_W  port A write data
dout_a  out  DATA_W  port A read data
vld_a  out  1  dout_a valid strobe
en_b, we_b, addr_b, din_b, dout_b, vld_b  as port A, for port B
busy  out  1  high during reset and the clear sequence; accesses ignored
collision  out  1  one-cycle pulse: same-cycle overlapping writes to one address

Behaviour:
- Reset (rst=1 at a clock edge): dout_a = dout_b = 0, vld_a = vld_b = 0, collision = 0, pipeline stages cleared, FSM → CLEAR, clear counter = 0, busy = 1. Memory is not written while rst = 1.
- FSM states:
  - CLEAR: each cycle with rst = 0, write 0 to mem[cnt] and increment cnt. After writing cnt = DEPTH-1 → RUN; busy drops on the same edge. The clear takes exactly DEPTH cycles after rst deasserts.
  - RUN: normal operation. busy = 0.
  - rst asserted in any state → CLEAR with cnt = 0, so reset mid-clear restarts the sweep.
- An access is issued when en_x = 1 and busy = 0. While busy, en/we are ignored: no write, no valid.
- Write: for each lane i with we_x[i] = 1, mem[addr][i] ← din_x[i]. Other lanes keep their value.
- Read: every issued access also reads.
  - RDW_MODE = 0: returns the pre-edge word.
  - RDW_MODE = 1: returns the post-write merged word, including writes from the other port in the same cycle.
- Latency:
  - OUT_REG = 0: dout_x and vld_x update on the edge after issue.
  - OUT_REG = 1: they update one edge later.
  - vld_x is a one-cycle pulse per issued access, aligned with dout_x. Back-to-back accesses give back-to-back valids.
  - dout_x holds its last value when no access is completing.
- Cross-port, same address, both writing:
  - Lanes enabled on both ports: port A wins.
  - Lanes enabled on one port only: written normally.
  - collision pulses on the next edge only if at least one lane overlaps.
- Cross-port, same address, one port reading: follows RDW_MODE.
- Address ≥ DEPTH: write discarded, read returns 0, vld still asserted.
- Widths: lane count NB = DATA_W/BYTE_W. Clear counter width = ADDR_W+1, so wrap cannot occur when DEPTH = 2**ADDR_W.

Decomposition:
- Package dp_ram_pkg holds:
  - RDW_READ_FIRST / RDW_WRITE_FIRST constants
  - the FSM state type {CLEAR, RUN}
  - a function computing NB from DATA_W and BYTE_W
- One sub-module, dp_ram_out_pipe: a per-port registered {vld, dout} stage with sync reset, instantiated once per port when OUT_REG = 1 and bypassed otherwise.
- Core array, arbitration and FSM stay in dp_ram_be_clr.

Test Plan:
- Clear: pulse rst 1 cycle → busy = 1 for exactly 16 cycles after deassert. Then read all 16 addresses on A → dout_a = 0x00 each, vld_a asserted 2 cycles after each issue (OUT_REG = 1).
- Byte enables (DATA_W = 32, BYTE_W = 8): write 0xAABBCCDD to addr 3 with we = 4'b1111, then 0x11223344 with we = 4'b0101 → read addr 3 returns 0xAA22CC44.
- Collision (DATA_W = 32): same cycle, A writes addr 5 = 0x11111111 with we = 4'b0011; B writes addr 5 = 0x22222222 with we = 4'b0110.
  - Expect collision = 1 for one cycle.
  - Read returns 0x00221111, i.e. lane 1 from A, lane 2 from B, lane 3 at its cleared value 0x00.
- RDW: addr 2 holds 0x5A; A writes 0xA5 to addr 2 while B reads addr 2.
  - RDW_MODE = 0 → dout_b = 0x5A.
  - RDW_MODE = 1 → dout_b = 0xA5.
- Busy gating: assert en_a = 1, we_a = 1, din_a = 0xFF to addr 0 during the clear sweep → no vld_a. After busy drops, addr 0 reads 0x00.
- Reset mid-clear: assert rst at clear cycle 7 → busy stays high for a full 16 cycles after the new deassert. Outputs are 0 and valids are low during rst.
